// File: rtl/magic_pkg.sv
// magic_pkg: shared types and width helpers for the MAGIC NOR/INV sequencer
package magic_pkg;
  function automatic int cw_of(input int ncells);
    return ncells > 1 ? $clog2(ncells) : 1;
  endfunction
  function automatic int pw_of(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  localparam int CELL_W = cw_of(32);
  typedef enum logic [1:0] {OP_END, OP_INV, OP_NOR, OP_ILL} op_t;
  typedef struct packed {
    op_t op;
    logic [CELL_W-1:0] src_a;
    logic [CELL_W-1:0] src_b;
    logic [CELL_W-1:0] dst;
  } instr_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_EVAL, S_DONE} state_t;
endpackage

// File: rtl/magic_cell_array.sv
// magic_cell_array: memristive bit-cells with input load, MAGIC init/eval write and read ports
module magic_cell_array
  import magic_pkg::*;
#(
  parameter int NCELLS = 32,
  parameter int NIN = 5,
  localparam int CW = cw_of(NCELLS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic [NIN-1:0] load_bits,
  input  logic [CW-1:0]  ra_addr,
  input  logic [CW-1:0]  rb_addr,
  output logic           ra,
  output logic           rb,
  input  logic           w_en,
  input  logic           w_init,
  input  logic [CW-1:0]  w_addr,
  input  logic           w_a,
  input  logic           w_b,
  input  logic [CW-1:0]  res_addr,
  output logic           res_bit
);
  logic [NCELLS-1:0] cells;
  logic w_val;
  assign ra = cells[ra_addr];
  assign rb = cells[rb_addr];
  assign w_val = w_init | (cells[w_addr] & ~(w_a | w_b));
  assign res_bit = (w_en && w_addr == res_addr) ? w_val : cells[res_addr];
  // cell update: bulk load of inputs, or set-to-1 / switch-only-to-0 gate write
  always_ff @(posedge clk) begin
    if (rst) cells <= '0;
    else begin
      if (load_en) cells[NIN-1:0] <= load_bits;
      if (w_en) cells[w_addr] <= w_val;
    end
  end
endmodule

// File: rtl/magic_nor_sequencer.sv
// magic_nor_sequencer: runs a stored NOR/INV program on a MAGIC cell array, two cycles per gate
module magic_nor_sequencer
  import magic_pkg::*;
#(
  parameter int NCELLS = 32,
  parameter int NIN = 5,
  parameter int PROG_DEPTH = 32,
  localparam int CW = cw_of(NCELLS),
  localparam int PW = pw_of(PROG_DEPTH),
  localparam int IW = 2 + 3 * CW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           prog_we,
  input  logic [PW-1:0]  prog_addr,
  input  logic [IW-1:0]  prog_wdata,
  input  logic [NIN-1:0] in_bits,
  input  logic [CW-1:0]  res_sel,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           result,
  output logic           err
);
  state_t state, nxt;
  logic [PW-1:0] pc;
  logic [CW-1:0] res_q;
  logic [IW-1:0] mem [PROG_DEPTH];
  logic [IW-1:0] ins;
  op_t op;
  logic [CW-1:0] sa, sb, sd;
  logic ca, cb, res_bit, bad, load_en, w_en, w_init;
  assign ins = mem[pc];
  assign op = op_t'(ins[IW-1 -: 2]);
  assign sa = ins[3*CW-1 -: CW];
  assign sb = ins[2*CW-1 -: CW];
  assign sd = ins[CW-1:0];
  assign bad = op == OP_ILL || int'(sa) >= NCELLS || int'(sb) >= NCELLS || int'(sd) >= NCELLS
             || sd == sa || (op == OP_NOR && sd == sb);
  assign load_en = state == S_LOAD;
  assign w_init = state == S_INIT;
  assign w_en = state == S_EVAL || (state == S_INIT && op != OP_END && !bad);
  assign busy = state == S_LOAD || state == S_INIT || state == S_EVAL;
  assign done = state == S_DONE;
  magic_cell_array #(.NCELLS(NCELLS), .NIN(NIN)) u_cells (
    .clk(clk), .rst(rst), .load_en(load_en), .load_bits(in_bits),
    .ra_addr(sa), .rb_addr(sb), .ra(ca), .rb(cb),
    .w_en(w_en), .w_init(w_init), .w_addr(sd), .w_a(ca), .w_b(op == OP_NOR && cb),
    .res_addr(res_q), .res_bit(res_bit)
  );
  // next-state: INIT aborts to DONE on END or a bad instruction, EVAL ends after the last slot
  always_comb begin
    nxt = state == S_IDLE ? (start ? S_LOAD : S_IDLE)
        : state == S_LOAD ? S_INIT
        : state == S_INIT ? ((op == OP_END || bad) ? S_DONE : S_EVAL)
        : state == S_EVAL ? (pc == PW'(PROG_DEPTH - 1) ? S_DONE : S_INIT)
        : S_IDLE;
  end
  // state, pc, latched result select, sticky error and result captured on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= '0;
      res_q <= '0;
      result <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        res_q <= res_sel;
        err <= 1'b0;
        pc <= '0;
      end
      if (state == S_INIT && op != OP_END && bad) err <= 1'b1;
      if (state == S_EVAL) pc <= pc + 1'b1;
      if (nxt == S_DONE) result <= res_bit;
    end
  end
  // program memory is writable only while idle and is never cleared
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE) mem[prog_addr] <= prog_wdata;
  end
endmodule
